// File: rtl/uart_tx_if.sv
// Parallel side of the UART transmitter: register-file inputs, serial line and status.
// Handshake: tx_load is a one-cycle request that is accepted only on an edge where
// tf_TXRDY=1; a request seen while tf_TXRDY=0 is dropped with no side effects.
interface uart_tx_if #(
  parameter int BITWIDTH = 8
);
  logic [BITWIDTH-1:0] o_baud_val;
  logic [BITWIDTH-1:0] data_in;
  logic                tx_load;
  logic                tx;
  logic                tf_TXRDY;
  logic                tx_busy;

  modport master (
    output o_baud_val, data_in, tx_load,
    input  tx, tf_TXRDY, tx_busy
  );

  modport slave (
    input  o_baud_val, data_in, tx_load,
    output tx, tf_TXRDY, tx_busy
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: one-entry holding register feeding a start/data/stop shifter
// with 16x oversampled bit timing derived from a per-frame latched baud divisor.
module uart_tx_engine #(
  parameter int BITWIDTH = 8
) (
  input  logic      pclk,
  input  logic      presetn,
  uart_tx_if.slave  bus,
  output logic [1:0] state_dbg
);

  localparam int IDX_W = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BITWIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [BITWIDTH-1:0]  hold_q;
  logic                 hold_full_q;
  logic [BITWIDTH-1:0]  shift_q;
  logic [BITWIDTH-1:0]  bv_q;
  logic [BITWIDTH-1:0]  baud_cnt_q;
  logic [3:0]           os_cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic                 tx_q, tx_d;

  logic tick, bit_done, last_bit;
  logic load_shift, shift_bit;

  assign tick     = (baud_cnt_q == bv_q);
  assign bit_done = tick && (os_cnt_q == 4'hF);
  assign last_bit = (bit_idx_q == LAST_IDX);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hold_full_q) state_d = START;
      START:   if (bit_done) state_d = DATA;
      DATA:    if (bit_done && last_bit) state_d = STOP;
      STOP:    if (bit_done) state_d = hold_full_q ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tx_d is the value the line takes after this edge; tx itself is a flop.
  always_comb begin
    tx_d       = tx_q;
    load_shift = 1'b0;
    shift_bit  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (hold_full_q) begin
          load_shift = 1'b1;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          shift_bit = 1'b1;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (last_bit) begin
            tx_d = 1'b1;
          end else begin
            shift_bit = 1'b1;
            tx_d      = shift_q[0];
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_done && hold_full_q) begin
          load_shift = 1'b1;
          tx_d       = 1'b0;
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

  // A transfer edge always sees a full holding register, so a coincident
  // tx_load is dropped naturally.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bv_q        <= '0;
      baud_cnt_q  <= '0;
      os_cnt_q    <= '0;
      bit_idx_q   <= '0;
      tx_q        <= 1'b1;
    end else begin
      tx_q <= tx_d;
      if (load_shift) begin
        shift_q     <= hold_q;
        bv_q        <= bus.o_baud_val;
        hold_full_q <= 1'b0;
        baud_cnt_q  <= '0;
        os_cnt_q    <= '0;
        bit_idx_q   <= '0;
      end else begin
        if (bus.tx_load && !hold_full_q) begin
          hold_q      <= bus.data_in;
          hold_full_q <= 1'b1;
        end
        if (shift_bit) begin
          shift_q <= shift_q >> 1;
        end
        if (state_q != IDLE) begin
          baud_cnt_q <= tick ? '0 : baud_cnt_q + 1'b1;
          if (tick) begin
            os_cnt_q <= os_cnt_q + 4'd1;
          end
          if (bit_done && (state_q == DATA)) begin
            bit_idx_q <= bit_idx_q + 1'b1;
          end
        end
      end
    end
  end

  assign bus.tx       = tx_q;
  assign bus.tf_TXRDY = ~hold_full_q;
  assign bus.tx_busy  = (state_q != IDLE);
  assign state_dbg    = state_q;

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter: BITWIDTH, default 8, width of the data and baud-value buses.
REQ-002 pclk  input  1  system clock; all state updates on the rising edge.
REQ-003 presetn  input  1  reset; asynchronous, active-low.
REQ-004 o_baud_val  input  BITWIDTH  baud divisor from the APB register file.
REQ-005 data_in  input  BITWIDTH  transmit byte from the APB register file.
REQ-006 tx_load  input  1  one-cycle strobe requesting that data_in be queued.
REQ-007 tx  output  1  serial line; idle high.
REQ-008 tf_TXRDY  output  1  holding register empty; feeds the APB slave TX_RDY status.
REQ-009 tx_busy  output  1  a frame is in progress (state other than IDLE).

Function
REQ-010 The block SHALL contain a one-entry holding register, a shift register, a baud counter, a 4-bit oversample counter and a bit index.
REQ-011 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-012 tf_TXRDY SHALL be 1 exactly when the holding register is empty.
REQ-013 tx_load with tf_TXRDY=1 SHALL capture data_in into the holding register at that edge; tf_TXRDY SHALL read 0 from the next cycle.
REQ-014 tx_load with tf_TXRDY=0 SHALL be ignored: there is no overwrite and no state change.
REQ-015 In IDLE with the holding register full, the next edge SHALL:
- move the holding data to the shift register;
- latch o_baud_val;
- clear the holding register (tf_TXRDY=1);
- enter START with tx=0.
REQ-016 The latched baud value BV SHALL stay fixed for the whole frame; changes to o_baud_val mid-frame SHALL take effect only at the next frame.
REQ-017 The baud counter SHALL count 0..BV and emit one tick per BV+1 cycles; each bit SHALL last 16 ticks, i.e. 16*(BV+1) pclk cycles.
REQ-018 BV=0 SHALL be legal and give a 16-cycle bit.
REQ-019 The baud and oversample counters SHALL restart at 0 when START is entered.
REQ-020 START SHALL drive tx=0 for one bit time, then enter DATA.
REQ-021 DATA SHALL shift out BITWIDTH bits LSB first, one bit time each, then enter STOP.
REQ-022 STOP SHALL drive tx=1 for one bit time.
REQ-023 At the end of STOP:
- if the holding register is full, the FSM SHALL load it and enter START on the same edge, with no idle gap;
- otherwise it SHALL enter IDLE.
REQ-024 A tx_load in the same cycle as a holding-to-shift transfer SHALL be ignored, since tf_TXRDY is 0 in that cycle.
REQ-025 tx SHALL be driven from a register, with no combinational glitches.
REQ-026 Total frame length SHALL be (BITWIDTH+2)*16*(BV+1) cycles.

Reset
REQ-027 presetn=0 SHALL immediately force:
- FSM=IDLE, tx=1, tf_TXRDY=1, tx_busy=0;
- holding register, shift register and all counters = 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame and discard any queued byte; tx SHALL go high without waiting for a clock.
REQ-029 After presetn rises, no frame SHALL start until a new tx_load.

Verification
REQ-030 Single byte: BV=0, one tx_load with 0xA5 while idle -> tf_TXRDY=0 for exactly 1 cycle; tx=0 from the 2nd edge; then 1,0,1,0,0,1,0,1 then stop 1, each 16 cycles; tx_busy high for exactly 160 cycles.
REQ-031 Back-to-back: BV=1, load 0x55, then load 0x0F during the first frame's DATA state -> tf_TXRDY low from that load until the first STOP ends; the second START begins on the cycle after the 32-cycle STOP with no idle cycle.
REQ-032 Overrun: with the holding register full, pulse tx_load with 0xFF -> ignored; the queued byte is transmitted unchanged.
REQ-033 Baud change: start a frame with BV=3, then change o_baud_val to 0 mid-frame -> remaining bits stay 64 cycles; the next frame uses 16-cycle bits.
REQ-034 Reset mid-frame: assert presetn=0 during DATA bit 3 with a byte queued -> tx=1 and tf_TXRDY=1 asynchronously; tx stays 1 after release with no tx_load.
REQ-035 Boundary data: 0x00 and 0xFF frames -> tx shows start 0, eight identical bits, stop 1; the correct bit count is checked by the frame length of 160 cycles at BV=0.
